sdf_check_monitor: RTL and testbench

Self-checking capture stage placed directly downstream of the three-flop SDF timing test pipeline. It taps the pipeline's primary inputs (`d1`, `d2`, `en`) and consumes its registered outputs (`q1`, `q2`, `q3`). For a programmed number of cycles it compares those outputs against a cycle-accurate golden model, then reports mismatch count, first-failure index and pass/fail. It is used in back-annotated simulation to flag SDF-induced functional failures without a testbench scoreboard.

---
 rtl/sdf_check_pkg.sv | 29 ++
 rtl/sdf_check_monitor_if.sv | 32 +++
 rtl/sdf_check_model.sv | 28 ++
 rtl/sdf_check_monitor.sv | 137 +++++++++++++
 tb/tb_sdf_check_monitor.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdf_check_pkg.sv
// Shared types and the golden function for the SDF pipeline check monitor.
package sdf_check_pkg;

  typedef enum logic [1:0] {
    SDF_IDLE   = 2'd0,
    SDF_CHECK  = 2'd1,
    SDF_REPORT = 2'd2
  } sdf_state_e;

  // Bit order {exp3, exp2, exp1}, matching {q3, q2, q1}.
  typedef logic [2:0] exp_vec_t;

  typedef struct packed {
    logic d1;
    logic d2;
    logic en;
  } sdf_stim_t;

  function automatic exp_vec_t sdf_expected(input logic d1, input logic d2, input logic en);
    logic e1;
    logic e2;
    logic e3;
    e1 = ~d1 | d2;
    e2 = ~(e1 & en);
    e3 = d1 & d2;
    return {e3, e2, e1};
  endfunction

endpackage

// File: rtl/sdf_check_monitor_if.sv
// Stimulus tap, observed pipeline outputs, run control and result bus of the monitor.
interface sdf_check_monitor_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
);

  logic             d1;
  logic             d2;
  logic             en;
  logic             q1;
  logic             q2;
  logic             q3;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [2:0]       first_err_vec;

  modport master (
    output d1, d2, en, q1, q2, q3, start, len,
    input  busy, done, pass, err_count, first_err_idx, first_err_vec
  );

  modport slave (
    input  d1, d2, en, q1, q2, q3, start, len,
    output busy, done, pass, err_count, first_err_idx, first_err_vec
  );

endinterface

// File: rtl/sdf_check_model.sv
// Registered golden model of the three-flop SDF test pipeline; updates every cycle.
module sdf_check_model
  import sdf_check_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  sdf_stim_t stim_i,
  output exp_vec_t  exp_o
);

  exp_vec_t exp_q;
  exp_vec_t exp_d;

  always_comb begin
    exp_d = sdf_expected(stim_i.d1, stim_i.d2, stim_i.en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/sdf_check_monitor.sv
// Run-length-bounded compare of pipeline outputs against the golden model, with
// saturating error count, first-failure capture and a one-cycle done pulse.
module sdf_check_monitor
  import sdf_check_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ERR_W      = 8,
  parameter logic [2:0]  CHECK_MASK = 3'b111
) (
  input logic                clk,
  input logic                rst,
  sdf_check_monitor_if.slave mon
);

  localparam logic [1:0] S_IDLE   = 2'(SDF_IDLE);
  localparam logic [1:0] S_CHECK  = 2'(SDF_CHECK);
  localparam logic [1:0] S_REPORT = 2'(SDF_REPORT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  sdf_stim_t stim_c;
  exp_vec_t  exp_vec;
  logic [2:0] obs_c;
  logic [2:0] mism_c;

  assign stim_c = '{d1: mon.d1, d2: mon.d2, en: mon.en};
  assign obs_c  = {mon.q3, mon.q2, mon.q1};
  assign mism_c = (obs_c ^ exp_vec) & CHECK_MASK;

  sdf_check_model u_model (
    .clk    (clk),
    .rst    (rst),
    .stim_i (stim_c),
    .exp_o  (exp_vec)
  );

  // Next-state, counters and result capture.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    err_d       = err_q;
    fidx_d      = fidx_q;
    fvec_d      = fvec_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (mon.start) begin
          remaining_d = mon.len;
          idx_d       = '0;
          err_d       = '0;
          fidx_d      = '0;
          fvec_d      = '0;
          if (mon.len == '0) begin
            state_d = S_REPORT;
            pass_d  = 1'b1;
          end else begin
            state_d = S_CHECK;
            pass_d  = 1'b0;
          end
        end
      end

      S_CHECK: begin
        if (mism_c != 3'b000) begin
          if (err_q == '0) begin
            fidx_d = idx_q;
            fvec_d = mism_c;
          end
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        remaining_d = remaining_q - CNT_W'(1);
        // The final compare stops idx at len-1 so a maximal len never wraps it.
        if (remaining_q == CNT_W'(1)) begin
          state_d = S_REPORT;
          pass_d  = (err_d == '0);
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == S_CHECK);
  assign done_d = (state_d == S_REPORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      fidx_q      <= '0;
      fvec_q      <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      fidx_q      <= fidx_d;
      fvec_q      <= fvec_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mon.busy          = busy_q;
  assign mon.done          = done_q;
  assign mon.pass          = pass_q;
  assign mon.err_count     = err_q;
  assign mon.first_err_idx = fidx_q;
  assign mon.first_err_vec = fvec_q;

endmodule

// File: tb/tb_sdf_check_monitor.sv
// Scoreboard bench: three monitors (default, mask 3'b101, 2-bit error counter) share one stimulus bus.
module tb_sdf_check_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        d1, d2, en, start;
  logic [15:0] len;
  logic [2:0]  qv;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sdf_check_monitor_if #(.CNT_W(16), .ERR_W(8)) if0 ();
  sdf_check_monitor_if #(.CNT_W(16), .ERR_W(8)) if1 ();
  sdf_check_monitor_if #(.CNT_W(16), .ERR_W(2)) if2 ();

  assign if0.d1 = d1;  assign if0.d2 = d2;  assign if0.en = en;
  assign if0.q1 = qv[0]; assign if0.q2 = qv[1]; assign if0.q3 = qv[2];
  assign if0.start = start; assign if0.len = len;
  assign if1.d1 = d1;  assign if1.d2 = d2;  assign if1.en = en;
  assign if1.q1 = qv[0]; assign if1.q2 = qv[1]; assign if1.q3 = qv[2];
  assign if1.start = start; assign if1.len = len;
  assign if2.d1 = d1;  assign if2.d2 = d2;  assign if2.en = en;
  assign if2.q1 = qv[0]; assign if2.q2 = qv[1]; assign if2.q3 = qv[2];
  assign if2.start = start; assign if2.len = len;

  sdf_check_monitor #(.CNT_W(16), .ERR_W(8), .CHECK_MASK(3'b111)) dut0 (.clk(clk), .rst(rst), .mon(if0));
  sdf_check_monitor #(.CNT_W(16), .ERR_W(8), .CHECK_MASK(3'b101)) dut1 (.clk(clk), .rst(rst), .mon(if1));
  sdf_check_monitor #(.CNT_W(16), .ERR_W(2), .CHECK_MASK(3'b111)) dut2 (.clk(clk), .rst(rst), .mon(if2));

  typedef struct {
    logic        pass;
    logic [7:0]  err;
    logic [15:0] fidx;
    logic [2:0]  fvec;
    int          lat;
  } res_t;

  res_t sb0[$];
  res_t sb1[$];
  res_t sb2[$];

  logic [2:0]  s_arr[16];   // {d1,d2,en} presented the cycle before compare k
  logic [2:0]  q_arr[16];   // {q3,q2,q1} observed during compare k
  logic        o_pass[3];
  logic [7:0]  o_err[3];
  logic [15:0] o_fidx[3];
  logic [2:0]  o_fvec[3];
  int          o_lat;
  bit          o_timeout;
  int          o_busy_bad;

  // Truth table of the pipeline, indexed by {d1,d2,en}, result {q3,q2,q1}.
  function automatic logic [2:0] bexp(input logic [2:0] s);
    case (s)
      3'b000:  return 3'b011;
      3'b001:  return 3'b001;
      3'b010:  return 3'b011;
      3'b011:  return 3'b001;
      3'b100:  return 3'b010;
      3'b101:  return 3'b010;
      3'b110:  return 3'b111;
      3'b111:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push_expected(input int n);
    res_t       r;
    logic [2:0] mask;
    logic [2:0] m;
    int         maxe;
    int         err;
    for (int d = 0; d < 3; d++) begin
      mask   = (d == 1) ? 3'b101 : 3'b111;
      maxe   = (d == 2) ? 3 : 255;
      err    = 0;
      r.fidx = '0;
      r.fvec = '0;
      for (int k = 0; k < n; k++) begin
        m = (q_arr[k] ^ bexp(s_arr[k])) & mask;
        if (m != 3'b000) begin
          if (err == 0) begin
            r.fidx = 16'(k);
            r.fvec = m;
          end
          if (err < maxe) err++;
        end
      end
      r.err  = 8'(err);
      r.pass = (err == 0);
      r.lat  = n + 1;
      if (d == 0) sb0.push_back(r);
      else if (d == 1) sb1.push_back(r);
      else sb2.push_back(r);
    end
  endtask

  task automatic pop_all(output res_t a, output res_t b, output res_t c);
    a = sb0.pop_front();
    b = sb1.pop_front();
    c = sb2.pop_front();
  endtask

  task automatic snap();
    o_pass[0] = if0.pass; o_err[0] = if0.err_count;     o_fidx[0] = if0.first_err_idx; o_fvec[0] = if0.first_err_vec;
    o_pass[1] = if1.pass; o_err[1] = if1.err_count;     o_fidx[1] = if1.first_err_idx; o_fvec[1] = if1.first_err_vec;
    o_pass[2] = if2.pass; o_err[2] = 8'(if2.err_count); o_fidx[2] = if2.first_err_idx; o_fvec[2] = if2.first_err_vec;
  endtask

  // Presents start plus stimulus, plays q per compare, stops in the cycle where done is visible.
  task automatic drive_run(input int n, input bit mid);
    int cyc;
    push_expected(n);
    o_busy_bad   = 0;
    start        = 1'b1;
    len          = 16'(n);
    {d1, d2, en} = s_arr[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = mid && (k == 1);
      if (start) len = 16'd2;
      {d1, d2, en} = (k + 1 < n) ? s_arr[k+1] : 3'b000;
      qv = q_arr[k];
      if (if0.busy !== 1'b1) o_busy_bad++;
    end
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (if0.done !== 1'b1 && cyc < n + 5);
    o_timeout = (if0.done !== 1'b1);
    o_lat     = n + cyc;
    snap();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; {d1, d2, en} = 3'b000; qv = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if0.busy, if0.done, if0.pass} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {if0.busy, if0.done, if0.pass});
    end
    checks++;
    if (if0.err_count !== 8'd0) begin
      failures++; $display("FAIL reset_err got=%0d exp=0", if0.err_count);
    end
    checks++;
    if (if0.first_err_idx !== 16'd0 || if0.first_err_vec !== 3'b000) begin
      failures++; $display("FAIL reset_first got=%0d/%b exp=0/000", if0.first_err_idx, if0.first_err_vec);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    res_t e0, e1, e2;
    s_arr[0] = 3'b000; s_arr[1] = 3'b100; s_arr[2] = 3'b111; s_arr[3] = 3'b110;
    q_arr[0] = 3'b011; q_arr[1] = 3'b010; q_arr[2] = 3'b101; q_arr[3] = 3'b111;
    drive_run(4, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_timeout || o_lat != 5) begin
      failures++; $display("FAIL clean_latency got=%0d timeout=%0b exp=5", o_lat, o_timeout);
    end
    checks++;
    if (o_pass[0] !== 1'b1 || o_err[0] !== 8'd0) begin
      failures++; $display("FAIL clean_result got pass=%0b err=%0d exp pass=1 err=0", o_pass[0], o_err[0]);
    end
    checks++;
    if (o_busy_bad != 0) begin
      failures++; $display("FAIL clean_busy got=%0d low cycles exp=0", o_busy_bad);
    end
    @(posedge clk); #1;
    checks++;
    if (if0.done !== 1'b0 || if0.pass !== e0.pass) begin
      failures++; $display("FAIL clean_pulse got done=%0b pass=%0b exp done=0 pass=%0b", if0.done, if0.pass, e0.pass);
    end
  endtask

  task automatic test_single_fault();
    res_t e0, e1, e2;
    s_arr[0] = 3'b000; s_arr[1] = 3'b100; s_arr[2] = 3'b111; s_arr[3] = 3'b110;
    q_arr[0] = 3'b011; q_arr[1] = 3'b010; q_arr[2] = 3'b111; q_arr[3] = 3'b111;
    drive_run(4, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_pass[0] !== e0.pass || o_err[0] !== e0.err) begin
      failures++; $display("FAIL fault_result got pass=%0b err=%0d exp pass=%0b err=%0d", o_pass[0], o_err[0], e0.pass, e0.err);
    end
    checks++;
    if (o_fidx[0] !== e0.fidx || o_fvec[0] !== e0.fvec) begin
      failures++; $display("FAIL fault_first got=%0d/%b exp=%0d/%b", o_fidx[0], o_fvec[0], e0.fidx, e0.fvec);
    end
    checks++;
    if (o_pass[1] !== e1.pass || o_err[1] !== e1.err) begin
      failures++; $display("FAIL mask_result got pass=%0b err=%0d exp pass=%0b err=%0d", o_pass[1], o_err[1], e1.pass, e1.err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    res_t e0, e1, e2;
    for (int k = 0; k < 6; k++) begin
      s_arr[k] = 3'($urandom);
      q_arr[k] = ~bexp(s_arr[k]);
    end
    drive_run(6, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_err[2] !== e2.err || o_fidx[2] !== e2.fidx) begin
      failures++; $display("FAIL sat_err2 got err=%0d idx=%0d exp err=%0d idx=%0d", o_err[2], o_fidx[2], e2.err, e2.fidx);
    end
    checks++;
    if (o_err[0] !== e0.err || o_pass[0] !== e0.pass) begin
      failures++; $display("FAIL sat_err8 got err=%0d pass=%0b exp err=%0d pass=%0b", o_err[0], o_pass[0], e0.err, e0.pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero();
    res_t e0, e1, e2;
    s_arr[0] = 3'b101;
    drive_run(0, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_timeout || o_lat != e0.lat) begin
      failures++; $display("FAIL len0_latency got=%0d timeout=%0b exp=%0d", o_lat, o_timeout, e0.lat);
    end
    checks++;
    if (o_pass[0] !== 1'b1 || o_err[0] !== 8'd0) begin
      failures++; $display("FAIL len0_result got pass=%0b err=%0d exp pass=1 err=0", o_pass[0], o_err[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    res_t e0, e1, e2;
    for (int k = 0; k < 3; k++) begin
      s_arr[k] = 3'($urandom);
      q_arr[k] = bexp(s_arr[k]);
    end
    q_arr[1] = q_arr[1] ^ 3'b100;
    drive_run(3, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_err[0] !== e0.err || o_fvec[0] !== e0.fvec || o_fidx[0] !== e0.fidx) begin
      failures++; $display("FAIL b2b_first got err=%0d vec=%b idx=%0d exp err=%0d vec=%b idx=%0d",
                           o_err[0], o_fvec[0], o_fidx[0], e0.err, e0.fvec, e0.fidx);
    end
    // A start offered during the report cycle must be dropped.
    start = 1'b1; len = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (if0.busy !== 1'b0) begin
      failures++; $display("FAIL b2b_report_start got busy=%0b exp=0", if0.busy);
    end
    for (int k = 0; k < 2; k++) begin
      s_arr[k] = 3'($urandom);
      q_arr[k] = bexp(s_arr[k]);
    end
    drive_run(2, 1'b0);
    pop_all(e0, e1, e2);
    checks++;
    if (o_timeout || o_lat != e0.lat || o_pass[0] !== 1'b1 || o_err[0] !== 8'd0 || o_fvec[0] !== 3'b000) begin
      failures++; $display("FAIL b2b_second got lat=%0d pass=%0b err=%0d vec=%b exp lat=%0d pass=1 err=0 vec=000",
                           o_lat, o_pass[0], o_err[0], o_fvec[0], e0.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_start();
    res_t e0, e1, e2;
    for (int k = 0; k < 4; k++) begin
      s_arr[k] = 3'($urandom);
      q_arr[k] = bexp(s_arr[k]);
    end
    q_arr[3] = q_arr[3] ^ 3'b001;
    drive_run(4, 1'b1);
    pop_all(e0, e1, e2);
    checks++;
    if (o_timeout || o_lat != e0.lat) begin
      failures++; $display("FAIL mid_start_latency got=%0d timeout=%0b exp=%0d", o_lat, o_timeout, e0.lat);
    end
    checks++;
    if (o_err[0] !== e0.err || o_fidx[0] !== e0.fidx || o_pass[0] !== e0.pass) begin
      failures++; $display("FAIL mid_start_result got err=%0d idx=%0d pass=%0b exp err=%0d idx=%0d pass=%0b",
                           o_err[0], o_fidx[0], o_pass[0], e0.err, e0.fidx, e0.pass);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    for (int k = 0; k < 4; k++) s_arr[k] = 3'($urandom);
    start = 1'b1; len = 16'd4; {d1, d2, en} = s_arr[0];
    @(posedge clk); #1;
    start = 1'b0; {d1, d2, en} = s_arr[1]; qv = ~bexp(s_arr[0]);
    @(posedge clk); #1;
    checks++;
    if (if0.err_count !== 8'd1 || if0.busy !== 1'b1) begin
      failures++; $display("FAIL abort_progress got err=%0d busy=%0b exp err=1 busy=1", if0.err_count, if0.busy);
    end
    rst = 1'b1; qv = ~bexp(s_arr[1]);
    @(posedge clk); #1;
    checks++;
    if ({if0.busy, if0.done, if0.pass} !== 3'b000 || if0.err_count !== 8'd0 ||
        if0.first_err_idx !== 16'd0 || if0.first_err_vec !== 3'b000) begin
      failures++; $display("FAIL abort_reset got ctrl=%b err=%0d idx=%0d vec=%b exp all zero",
                           {if0.busy, if0.done, if0.pass}, if0.err_count, if0.first_err_idx, if0.first_err_vec);
    end
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++; $display("FAIL abort_no_done got done=1 exp=0");
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_fault();
    test_saturation();
    test_len_zero();
    test_back_to_back();
    test_mid_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
